spi_regbank_arbiter: RTL and testbench

//   Shares one single-port 32-bit register bank between the SPI slave (read on address

---
 rtl/spi_regbank_arbiter_if.sv | 42 ++++
 rtl/spi_regbank_arbiter.sv | 132 +++++++++++++
 tb/tb_spi_regbank_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_regbank_arbiter_if.sv
// spi_regbank_arbiter_if
//   Bundles the SPI-slave and CPU-bus signals that meet at the shared register bank.
//   slave  : the arbiter side (receives requests, returns data/ack/overflow)
//   master : the requester side (SPI slave logic and CPU memory map, or a testbench)
//   Signals:
//     SpiRdReq/SpiRdAddr      SPI read request pulse and word address
//     SpiRdData/SpiRdValid    SPI read data and its 1-cycle valid pulse
//     SpiWrReq/Addr/Data      SPI write pulse at MOSI frame completion
//     SpiWrOvf/OvfClr         sticky dropped-write flag and its clear
//     CpuReq/We/Addr/Wdata    CPU request, held until CpuAck
//     CpuRdata/CpuAck         CPU read data and 1-cycle access acknowledge
interface spi_regbank_arbiter_if #(
    parameter int unsigned AW = 4
);
    logic          SpiRdReq;
    logic [7:0]    SpiRdAddr;
    logic [31:0]   SpiRdData;
    logic          SpiRdValid;
    logic          SpiWrReq;
    logic [7:0]    SpiWrAddr;
    logic [31:0]   SpiWrData;
    logic          SpiWrOvf;
    logic          OvfClr;
    logic          CpuReq;
    logic          CpuWe;
    logic [AW-1:0] CpuAddr;
    logic [31:0]   CpuWdata;
    logic [31:0]   CpuRdata;
    logic          CpuAck;

    modport master (
        output SpiRdReq, SpiRdAddr, SpiWrReq, SpiWrAddr, SpiWrData, OvfClr,
               CpuReq, CpuWe, CpuAddr, CpuWdata,
        input  SpiRdData, SpiRdValid, SpiWrOvf, CpuRdata, CpuAck
    );

    modport slave (
        input  SpiRdReq, SpiRdAddr, SpiWrReq, SpiWrAddr, SpiWrData, OvfClr,
               CpuReq, CpuWe, CpuAddr, CpuWdata,
        output SpiRdData, SpiRdValid, SpiWrOvf, CpuRdata, CpuAck
    );
endinterface

// File: rtl/spi_regbank_arbiter.sv
// spi_regbank_arbiter
//   Arbitrates one single-port bank of DEPTH 32-bit words between SPI reads (absolute
//   priority), a one-entry SPI write buffer and the CPU bus (round-robin between the two).
//   The grant chosen in a cycle is registered; the bank access happens in the next cycle.
//   Ports:
//     Clk      system clock, rising edge
//     Reset_n  asynchronous active-low reset; clears bank, buffer and outputs
//     bus      spi_regbank_arbiter_if.slave (SPI read/write, CPU req/ack, overflow)
module spi_regbank_arbiter #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input logic                  Clk,
    input logic                  Reset_n,
    spi_regbank_arbiter_if.slave bus
);

    typedef enum logic [1:0] {GIdle, GSpiRd, GSpiWr, GCpu} grant_e;

    grant_e          grant_q, grant_d;
    logic            rr_q, rr_d;          // 1: write buffer wins the next contested cycle
    logic [31:0]     bank_q [DEPTH];
    logic            buf_valid_q, buf_valid_d;
    logic [AW-1:0]   buf_addr_q, buf_addr_d;
    logic [31:0]     buf_data_q, buf_data_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;  // entry taken out of the buffer at grant time
    logic [31:0]     wr_data_q, wr_data_d;
    logic [7:0]      rd_addr_q, rd_addr_d;
    logic            ovf_q, ovf_d;
    logic [31:0]     spi_rdata_q, spi_rdata, spi_rd_word;
    logic [31:0]     cpu_rdata_q, cpu_rdata;
    logic            cpu_pend, drain, wr_in_range, rd_in_range, wr_load, wr_drop;

    // CpuReq is still high in its ack cycle; that is the same request, not a new one.
    assign cpu_pend = bus.CpuReq && (grant_q != GCpu);

    always_comb begin
        grant_d = GIdle;
        rr_d    = rr_q;
        if (bus.SpiRdReq) begin
            grant_d = GSpiRd;
        end else if (buf_valid_q && cpu_pend) begin
            grant_d = rr_q ? GSpiWr : GCpu;
            rr_d    = ~rr_q;
        end else if (buf_valid_q) begin
            grant_d = GSpiWr;
        end else if (cpu_pend) begin
            grant_d = GCpu;
        end
    end

    // The buffer slot frees as soon as its drain is granted, so a write arriving in
    // that same cycle is accepted.
    always_comb begin
        drain       = (grant_d == GSpiWr);
        wr_in_range = ({24'd0, bus.SpiWrAddr} < DEPTH);
        wr_load     = bus.SpiWrReq && wr_in_range && (!buf_valid_q || drain);
        wr_drop     = bus.SpiWrReq && wr_in_range && buf_valid_q && !drain;
        buf_valid_d = buf_valid_q && !drain;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        if (wr_load) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = bus.SpiWrAddr[AW-1:0];
            buf_data_d  = bus.SpiWrData;
        end
        wr_addr_d = drain ? buf_addr_q : wr_addr_q;
        wr_data_d = drain ? buf_data_q : wr_data_q;
        rd_addr_d = bus.SpiRdReq ? bus.SpiRdAddr : rd_addr_q;
        ovf_d     = wr_drop || (ovf_q && !bus.OvfClr);
    end

    // SPI reads see a still-buffered write to the same word.
    always_comb begin
        rd_in_range = ({24'd0, rd_addr_q} < DEPTH);
        spi_rd_word = '0;
        if (rd_in_range) begin
            if (buf_valid_q && (buf_addr_q == rd_addr_q[AW-1:0])) begin
                spi_rd_word = buf_data_q;
            end else begin
                spi_rd_word = bank_q[rd_addr_q[AW-1:0]];
            end
        end
        spi_rdata = (grant_q == GSpiRd) ? spi_rd_word : spi_rdata_q;
        cpu_rdata = (grant_q == GCpu) ? bank_q[bus.CpuAddr] : cpu_rdata_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            grant_q     <= GIdle;
            rr_q        <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
            ovf_q       <= 1'b0;
            spi_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_addr_q   <= rd_addr_d;
            ovf_q       <= ovf_d;
            spi_rdata_q <= spi_rdata;
            cpu_rdata_q <= cpu_rdata;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bank_q <= '{default: '0};
        end else if (grant_q == GSpiWr) begin
            bank_q[wr_addr_q] <= wr_data_q;
        end else if ((grant_q == GCpu) && bus.CpuWe) begin
            bank_q[bus.CpuAddr] <= bus.CpuWdata;
        end
    end

    assign bus.SpiRdData  = spi_rdata;
    assign bus.SpiRdValid = (grant_q == GSpiRd);
    assign bus.CpuRdata   = cpu_rdata;
    assign bus.CpuAck     = (grant_q == GCpu);
    assign bus.SpiWrOvf   = ovf_q;

endmodule

// File: tb/tb_spi_regbank_arbiter.sv
module tb_spi_regbank_arbiter;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 Clk = ~Clk;

    spi_regbank_arbiter_if #(.AW(AW)) bus ();

    spi_regbank_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    task automatic idle_inputs();
        bus.SpiRdReq = 1'b0; bus.SpiRdAddr = '0;
        bus.SpiWrReq = 1'b0; bus.SpiWrAddr = '0; bus.SpiWrData = '0;
        bus.OvfClr   = 1'b0;
        bus.CpuReq   = 1'b0; bus.CpuWe = 1'b0; bus.CpuAddr = '0; bus.CpuWdata = '0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic next_cycle();
        @(posedge Clk); #1;
    endtask

    task automatic mid();
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset_n = 1'b0;
        next_cycle();
        mid();
        checks++; if (bus.SpiRdValid !== 1'b0) begin failures++;
            $display("FAIL rst_spi_valid got=%0h want=0", bus.SpiRdValid); end
        checks++; if (bus.SpiRdData !== 32'h0) begin failures++;
            $display("FAIL rst_spi_data got=%08h want=00000000", bus.SpiRdData); end
        checks++; if (bus.CpuAck !== 1'b0) begin failures++;
            $display("FAIL rst_cpu_ack got=%0h want=0", bus.CpuAck); end
        checks++; if (bus.CpuRdata !== 32'h0) begin failures++;
            $display("FAIL rst_cpu_rdata got=%08h want=00000000", bus.CpuRdata); end
        checks++; if (bus.SpiWrOvf !== 1'b0) begin failures++;
            $display("FAIL rst_ovf got=%0h want=0", bus.SpiWrOvf); end
        next_cycle();
        Reset_n = 1'b1;
        bus.SpiRdReq = 1'b1; bus.SpiRdAddr = 8'd9;
        next_cycle();
        bus.SpiRdReq = 1'b0;
        mid();
        checks++; if (bus.SpiRdValid !== 1'b1 || bus.SpiRdData !== 32'h0) begin failures++;
            $display("FAIL rst_bank9 got=%0h/%08h want=1/00000000", bus.SpiRdValid, bus.SpiRdData);
        end
        next_cycle();
    endtask

    task automatic test_cpu_write_spi_read();
        bus.CpuReq = 1'b1; bus.CpuWe = 1'b1; bus.CpuAddr = 4'd3; bus.CpuWdata = 32'h12345678;
        mid();
        checks++; if (bus.CpuAck !== 1'b0) begin failures++;
            $display("FAIL t1_ack_same_cycle got=%0h want=0", bus.CpuAck); end
        next_cycle(); mid();
        checks++; if (bus.CpuAck !== 1'b1) begin failures++;
            $display("FAIL t1_ack_next_cycle got=%0h want=1", bus.CpuAck); end
        next_cycle();
        bus.CpuReq = 1'b0; bus.CpuWe = 1'b0;
        bus.SpiRdReq = 1'b1; bus.SpiRdAddr = 8'd3;
        mid();
        checks++; if (bus.SpiRdValid !== 1'b0 || bus.CpuAck !== 1'b0) begin failures++;
            $display("FAIL t1_quiet got=%0h/%0h want=0/0", bus.SpiRdValid, bus.CpuAck); end
        next_cycle();
        bus.SpiRdReq = 1'b0;
        mid();
        checks++; if (bus.SpiRdValid !== 1'b1) begin failures++;
            $display("FAIL t1_rd_valid got=%0h want=1", bus.SpiRdValid); end
        checks++; if (bus.SpiRdData !== 32'h12345678) begin failures++;
            $display("FAIL t1_rd_data got=%08h want=12345678", bus.SpiRdData); end
        next_cycle(); mid();
        checks++; if (bus.SpiRdValid !== 1'b0) begin failures++;
            $display("FAIL t1_valid_pulse got=%0h want=0", bus.SpiRdValid); end
        next_cycle();
    endtask

    task automatic test_rd_priority();
        bus.SpiRdReq = 1'b1; bus.SpiRdAddr = 8'd3;
        bus.CpuReq = 1'b1; bus.CpuWe = 1'b0; bus.CpuAddr = 4'd3;
        next_cycle();
        bus.SpiRdReq = 1'b0;
        mid();
        checks++; if (bus.SpiRdValid !== 1'b1 || bus.CpuAck !== 1'b0) begin failures++;
            $display("FAIL t2_spi_first got=%0h/%0h want=1/0", bus.SpiRdValid, bus.CpuAck); end
        next_cycle(); mid();
        checks++; if (bus.CpuAck !== 1'b1 || bus.SpiRdValid !== 1'b0) begin failures++;
            $display("FAIL t2_cpu_second got=%0h/%0h want=1/0", bus.CpuAck, bus.SpiRdValid); end
        checks++; if (bus.CpuRdata !== 32'h12345678) begin failures++;
            $display("FAIL t2_cpu_rdata got=%08h want=12345678", bus.CpuRdata); end
        next_cycle();
        bus.CpuReq = 1'b0;
        mid();
        checks++; if (bus.CpuAck !== 1'b0 || bus.SpiRdData !== 32'h12345678) begin failures++;
            $display("FAIL t2_hold got=%0h/%08h want=0/12345678", bus.CpuAck, bus.SpiRdData); end
        next_cycle();
    endtask

    task automatic test_rr_overflow();
        logic [7:0]  raddr [4];
        logic [31:0] rexp  [4];
        logic [3:0]  acks;
        raddr = '{8'd1, 8'd2, 8'd4, 8'd7};
        rexp  = '{32'hD1D1_0001, 32'hD2D2_0002, 32'h0, 32'hCCCC_0002};
        do_reset();
        // c0: CPU write and first SPI write together; buffer empty so CPU is granted
        bus.CpuReq = 1'b1; bus.CpuWe = 1'b1; bus.CpuAddr = 4'd7; bus.CpuWdata = 32'hCCCC_0001;
        bus.SpiWrReq = 1'b1; bus.SpiWrAddr = 8'd1; bus.SpiWrData = 32'hD1D1_0001;
        mid(); acks[0] = bus.CpuAck;
        // c1: buffer drains, second write refills it
        next_cycle();
        bus.SpiWrAddr = 8'd2; bus.SpiWrData = 32'hD2D2_0002;
        mid(); acks[1] = bus.CpuAck;
        // c2: CPU re-requests, buffer full, CPU's turn; third write is dropped
        next_cycle();
        bus.CpuWdata = 32'hCCCC_0002;
        bus.SpiWrAddr = 8'd4; bus.SpiWrData = 32'hD3D3_0003;
        mid(); acks[2] = bus.CpuAck;
        checks++; if (bus.SpiWrOvf !== 1'b0) begin failures++;
            $display("FAIL t3_ovf_early got=%0h want=0", bus.SpiWrOvf); end
        next_cycle();
        bus.SpiWrReq = 1'b0;
        mid(); acks[3] = bus.CpuAck;
        checks++; if (bus.SpiWrOvf !== 1'b1) begin failures++;
            $display("FAIL t3_ovf_set got=%0h want=1", bus.SpiWrOvf); end
        checks++; if (acks !== 4'b1010) begin failures++;
            $display("FAIL t3_ack_pattern got=%b want=1010 (c3..c0)", acks); end
        next_cycle();
        bus.CpuReq = 1'b0; bus.CpuWe = 1'b0; bus.OvfClr = 1'b1;
        mid();
        checks++; if (bus.SpiWrOvf !== 1'b1 || bus.CpuAck !== 1'b0) begin failures++;
            $display("FAIL t3_c4 got=%0h/%0h want=1/0", bus.SpiWrOvf, bus.CpuAck); end
        next_cycle();
        bus.OvfClr = 1'b0;
        mid();
        checks++; if (bus.SpiWrOvf !== 1'b0) begin failures++;
            $display("FAIL t3_ovf_clr got=%0h want=0", bus.SpiWrOvf); end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            bus.SpiRdReq = 1'b1; bus.SpiRdAddr = raddr[i];
            next_cycle();
            bus.SpiRdReq = 1'b0;
            mid();
            checks++; if (bus.SpiRdValid !== 1'b1 || bus.SpiRdData !== rexp[i]) begin failures++;
                $display("FAIL t3_bank_%0d got=%0h/%08h want=1/%08h", raddr[i], bus.SpiRdValid,
                         bus.SpiRdData, rexp[i]);
            end
        end
        next_cycle();
    endtask

    task automatic test_forwarding();
        bus.SpiWrReq = 1'b1; bus.SpiWrAddr = 8'd5; bus.SpiWrData = 32'hA5A5A5A5;
        next_cycle();
        bus.SpiWrReq = 1'b0; bus.SpiRdReq = 1'b1; bus.SpiRdAddr = 8'd5;
        next_cycle();
        bus.SpiRdReq = 1'b0;
        mid();
        checks++; if (bus.SpiRdValid !== 1'b1 || bus.SpiRdData !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL t4_forward got=%0h/%08h want=1/a5a5a5a5", bus.SpiRdValid,
                     bus.SpiRdData);
        end
        next_cycle();
    endtask

    task automatic test_out_of_range();
        bus.SpiRdReq = 1'b1; bus.SpiRdAddr = 8'h20;
        next_cycle();
        bus.SpiRdReq = 1'b0;
        bus.SpiWrReq = 1'b1; bus.SpiWrAddr = 8'd6; bus.SpiWrData = 32'h0000_0001;
        mid();
        checks++; if (bus.SpiRdValid !== 1'b1 || bus.SpiRdData !== 32'h0) begin failures++;
            $display("FAIL t5_oor_read got=%0h/%08h want=1/00000000", bus.SpiRdValid,
                     bus.SpiRdData);
        end
        // buffer holds addr 6 and the read wins, so an in-range write here would overflow
        next_cycle();
        bus.SpiWrAddr = 8'h25; bus.SpiWrData = 32'hDEADBEEF;
        bus.SpiRdReq = 1'b1; bus.SpiRdAddr = 8'd5;
        next_cycle();
        idle_inputs();
        mid();
        checks++; if (bus.SpiRdData !== 32'hA5A5A5A5) begin failures++;
            $display("FAIL t5_bank5 got=%08h want=a5a5a5a5", bus.SpiRdData); end
        next_cycle(); mid();
        checks++; if (bus.SpiWrOvf !== 1'b0) begin failures++;
            $display("FAIL t5_no_ovf got=%0h want=0", bus.SpiWrOvf); end
        next_cycle();
        bus.SpiRdReq = 1'b1; bus.SpiRdAddr = 8'd6;
        next_cycle();
        bus.SpiRdReq = 1'b0;
        mid();
        checks++; if (bus.SpiRdData !== 32'h0000_0001) begin failures++;
            $display("FAIL t5_bank6 got=%08h want=00000001", bus.SpiRdData); end
        next_cycle();
    endtask

    task automatic test_reset_abort();
        bus.CpuReq = 1'b1; bus.CpuWe = 1'b0; bus.CpuAddr = 4'd5;
        next_cycle(); mid();
        checks++; if (bus.CpuAck !== 1'b1 || bus.CpuRdata !== 32'hA5A5A5A5) begin failures++;
            $display("FAIL t6_cpu_read got=%0h/%08h want=1/a5a5a5a5", bus.CpuAck, bus.CpuRdata);
        end
        next_cycle();
        bus.CpuWe = 1'b1; bus.CpuWdata = 32'h0000_0055;
        mid();
        Reset_n = 1'b0;
        #1;
        checks++; if ({bus.SpiRdValid, bus.CpuAck, bus.SpiWrOvf} !== 3'b000) begin failures++;
            $display("FAIL t6_rst_flags got=%b want=000",
                     {bus.SpiRdValid, bus.CpuAck, bus.SpiWrOvf});
        end
        checks++; if (bus.SpiRdData !== 32'h0 || bus.CpuRdata !== 32'h0) begin failures++;
            $display("FAIL t6_rst_data got=%08h/%08h want=0/0", bus.SpiRdData, bus.CpuRdata); end
        next_cycle();
        checks++; if (bus.CpuAck !== 1'b0) begin failures++;
            $display("FAIL t6_no_ack got=%0h want=0", bus.CpuAck); end
        idle_inputs();
        Reset_n = 1'b1;
        bus.SpiRdReq = 1'b1; bus.SpiRdAddr = 8'd5;
        next_cycle();
        bus.SpiRdReq = 1'b0;
        mid();
        checks++; if (bus.SpiRdValid !== 1'b1 || bus.SpiRdData !== 32'h0 || bus.CpuAck !== 1'b0)
        begin
            failures++;
            $display("FAIL t6_bank_cleared got=%0h/%08h/%0h want=1/0/0", bus.SpiRdValid,
                     bus.SpiRdData, bus.CpuAck);
        end
        next_cycle();
    endtask

    // Serial transaction model: each cycle at most one of {spi read, buffer drain, cpu}
    // is chosen; its effect is applied to the model bank immediately and its outputs
    // are expected in the following cycle.
    task automatic test_random();
        logic [31:0] mbank [16];
        bit          mfull, cpu_turn, ack_seen, do_rd, do_wr, do_cpu, cpu_wants;
        logic [3:0]  maddr;
        logic [31:0] mdata;
        logic        e_rdv, e_ack, e_ovf, n_ovf;
        logic [31:0] e_rdd, e_crd;
        do_reset();
        foreach (mbank[i]) mbank[i] = '0;
        mfull = 0; cpu_turn = 1; ack_seen = 0; maddr = '0; mdata = '0;
        e_rdv = 0; e_ack = 0; e_ovf = 0; e_rdd = '0; e_crd = '0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            bus.SpiRdReq  = ($urandom_range(0, 3) == 0);
            bus.SpiRdAddr = 8'($urandom_range(0, 19));
            bus.SpiWrReq  = ($urandom_range(0, 2) == 0);
            bus.SpiWrAddr = 8'($urandom_range(0, 19));
            bus.SpiWrData = $urandom;
            bus.OvfClr    = ($urandom_range(0, 9) == 0);
            if (!(bus.CpuReq && !ack_seen)) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.CpuReq = 1'b1; bus.CpuWe = 1'($urandom_range(0, 1));
                    bus.CpuAddr = 4'($urandom_range(0, 15)); bus.CpuWdata = $urandom;
                end else begin
                    bus.CpuReq = 1'b0;
                end
            end
            mid();
            checks++; if (bus.SpiRdValid !== e_rdv) begin failures++;
                $display("FAIL rnd_rd_valid cyc=%0d got=%0h want=%0h", cyc, bus.SpiRdValid, e_rdv);
            end
            checks++; if (bus.SpiRdData !== e_rdd) begin failures++;
                $display("FAIL rnd_rd_data cyc=%0d got=%08h want=%08h", cyc, bus.SpiRdData, e_rdd);
            end
            checks++; if (bus.CpuAck !== e_ack) begin failures++;
                $display("FAIL rnd_cpu_ack cyc=%0d got=%0h want=%0h", cyc, bus.CpuAck, e_ack);
            end
            checks++; if (bus.CpuRdata !== e_crd) begin failures++;
                $display("FAIL rnd_cpu_rdata cyc=%0d got=%08h want=%08h", cyc, bus.CpuRdata,
                         e_crd);
            end
            checks++; if (bus.SpiWrOvf !== e_ovf) begin failures++;
                $display("FAIL rnd_ovf cyc=%0d got=%0h want=%0h", cyc, bus.SpiWrOvf, e_ovf);
            end
            ack_seen = bus.CpuAck;

            do_rd = bus.SpiRdReq; do_wr = 0; do_cpu = 0;
            cpu_wants = bus.CpuReq && !e_ack;
            if (!do_rd) begin
                if (mfull && cpu_wants) begin
                    do_cpu = cpu_turn; do_wr = !cpu_turn; cpu_turn = !cpu_turn;
                end else if (mfull) begin
                    do_wr = 1;
                end else if (cpu_wants) begin
                    do_cpu = 1;
                end
            end
            n_ovf = e_ovf && !bus.OvfClr;
            if (do_wr) begin
                mbank[maddr] = mdata; mfull = 0;
            end
            if (do_cpu) begin
                e_crd = mbank[bus.CpuAddr];
                if (bus.CpuWe) mbank[bus.CpuAddr] = bus.CpuWdata;
            end
            if (bus.SpiWrReq && bus.SpiWrAddr < 8'd16) begin
                if (!mfull) begin
                    mfull = 1; maddr = bus.SpiWrAddr[3:0]; mdata = bus.SpiWrData;
                end else begin
                    n_ovf = 1;
                end
            end
            if (do_rd) begin
                if (bus.SpiRdAddr >= 8'd16) e_rdd = '0;
                else if (mfull && maddr == bus.SpiRdAddr[3:0]) e_rdd = mdata;
                else e_rdd = mbank[bus.SpiRdAddr[3:0]];
            end
            e_rdv = do_rd; e_ack = do_cpu; e_ovf = n_ovf;
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_cpu_write_spi_read();
        test_rd_priority();
        test_rr_overflow();
        test_forwarding();
        test_out_of_range();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
